debounce_bank: RTL

Parametrised multi-channel debouncer for front-panel buttons and switches. Each channel has its own input synchroniser, qualification counter and edge-pulse outputs. A shared clock-enable (`ce`) lets one upstream prescaler stretch the debounce window without widening the counters. The block replaces the fixed 8-bit debounce bus between the raw panel pins and the control/register logic.

---
 rtl/debounce_bank.sv | 138 +++++++++++++
 1 files changed

// File: rtl/debounce_bank.sv
// debounce_bank: per-channel synchroniser + qualification counter with registered edge pulses.
// Optional long-press detector is built when DEBOUNCE_HOLD_EN is defined; otherwise hold is tied low.
module debounce_bank #(
  parameter int unsigned         num_bits    = 8,
  parameter int unsigned         DBtime      = 8,
  parameter int unsigned         sync_stages = 2,
  parameter logic [num_bits-1:0] RESET_VAL   = '0,
  parameter int unsigned         HOLD_TIME   = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [num_bits-1:0] button,
  input  logic                ce,
  output logic [num_bits-1:0] result,
  output logic [num_bits-1:0] rise,
  output logic [num_bits-1:0] fall,
  output logic                changed,
  output logic [num_bits-1:0] hold
);

  localparam int unsigned   CW       = (DBtime > 1) ? $clog2(DBtime) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DBtime - 1);

  logic [num_bits-1:0] sync_q [sync_stages];
  logic [num_bits-1:0] sync_d [sync_stages];
  logic [CW-1:0]       cnt_q  [num_bits];
  logic [CW-1:0]       cnt_d  [num_bits];
  logic [num_bits-1:0] result_q, result_d;
  logic [num_bits-1:0] rise_q, rise_d;
  logic [num_bits-1:0] fall_q, fall_d;
  logic                changed_q, changed_d;
  logic [num_bits-1:0] s;

  always_comb begin
    sync_d[0] = button;
    for (int unsigned k = 1; k < sync_stages; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s = sync_q[sync_stages-1];

  // A match clears the count regardless of ce, so any glitch back restarts qualification.
  always_comb begin
    result_d = result_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int unsigned i = 0; i < num_bits; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s[i] == result_q[i]) begin
        cnt_d[i] = '0;
      end else if (ce) begin
        if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]    = '0;
          result_d[i] = s[i];
          rise_d[i]   = s[i];
          fall_d[i]   = ~s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < sync_stages; k++) begin
        sync_q[k] <= RESET_VAL;
      end
      for (int unsigned i = 0; i < num_bits; i++) begin
        cnt_q[i] <= '0;
      end
      result_q  <= RESET_VAL;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < sync_stages; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int unsigned i = 0; i < num_bits; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      result_q  <= result_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign result  = result_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;

`ifdef DEBOUNCE_HOLD_EN
  localparam int unsigned   HW        = $clog2(HOLD_TIME + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TIME);

  logic [HW-1:0]       hold_cnt_q [num_bits];
  logic [HW-1:0]       hold_cnt_d [num_bits];
  logic [num_bits-1:0] hold_q, hold_d;

  // Counter saturates at HOLD_TIME so the pulse fires once per press.
  always_comb begin
    hold_d = '0;
    for (int unsigned i = 0; i < num_bits; i++) begin
      hold_cnt_d[i] = hold_cnt_q[i];
      if (!result_q[i]) begin
        hold_cnt_d[i] = '0;
      end else if (ce && (hold_cnt_q[i] != HOLD_LAST)) begin
        hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
        hold_d[i]     = (hold_cnt_q[i] == (HOLD_LAST - 1'b1));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < num_bits; i++) begin
        hold_cnt_q[i] <= '0;
      end
      hold_q <= '0;
    end else begin
      for (int unsigned i = 0; i < num_bits; i++) begin
        hold_cnt_q[i] <= hold_cnt_d[i];
      end
      hold_q <= hold_d;
    end
  end

  assign hold = hold_q;
`else
  assign hold = '0;
`endif

endmodule
